// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers the VGA raster from raw h_sync/v_sync, checks line/frame
// timing, and regenerates pixel address, active-video qualifier and frame pulse.
//
// state   | meaning
// SEARCH  | waiting for a v_sync falling edge to align the counters
// ACQUIRE | counting clean frames toward lock
// LOCKED  | timing verified; addr/pixel_valid/frame_start are live
module vga_sync_decoder #(
  parameter logic [9:0] H_TOTAL     = 10'd800,
  parameter logic [9:0] V_TOTAL     = 10'd525,
  parameter logic [7:0] H_SYNC      = 8'd96,
  parameter logic [3:0] V_SYNC      = 4'd2,
  parameter logic [9:0] H_ACT_START = 10'd143,
  parameter logic [9:0] H_ACT_END   = 10'd782,
  parameter logic [9:0] V_ACT_START = 10'd35,
  parameter logic [9:0] V_ACT_END   = 10'd514,
  parameter logic [3:0] LOCK_FRAMES = 4'd2
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        h_sync,
  input  logic        v_sync,
  output logic [18:0] addr,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic        locked,
  output logic [9:0]  line_len,
  output logic [9:0]  frame_lines,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {SEARCH = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;
  state_t state_q, state_d;

  logic        hs_q, hs_d, hs_prev_q, hs_prev_d;
  logic        vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [7:0]  hpw_q, hpw_d;
  logic [3:0]  vpw_q, vpw_d;
  logic        have_edge_q, have_edge_d;
  logic [3:0]  good_q, good_d;
  logic        vfall_dly_q, vfall_dly_d;
  logic [9:0]  line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic [18:0] addr_q, addr_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic        frame_start_q, frame_start_d;
  logic        locked_q, locked_d;
  logic [7:0]  err_count_q, err_count_d;

  logic        hfall, hrise, vfall, vrise;
  logic [10:0] h_len_ext, v_len_ext;
  logic [9:0]  h_meas, v_meas;
  logic        err_line, err_hpw, err_frame, err_vpw, err_stuck, err_event;
  logic [9:0]  col;
  logic [8:0]  row;
  logic        h_in, v_in;

  assign hfall = hs_prev_q & ~hs_q;
  assign hrise = ~hs_prev_q & hs_q;
  assign vfall = vs_prev_q & ~vs_q;
  assign vrise = ~vs_prev_q & vs_q;

  assign h_len_ext = {1'b0, h_cnt_q} + 11'd1;
  assign v_len_ext = {1'b0, v_cnt_q} + 11'd1;
  assign h_meas    = h_len_ext[10] ? 10'h3FF : h_len_ext[9:0];
  assign v_meas    = v_len_ext[10] ? 10'h3FF : v_len_ext[9:0];

  // The first h_sync edge after alignment has no preceding line to measure.
  assign err_line  = hfall && have_edge_q && (h_meas != H_TOTAL);
  assign err_hpw   = hrise && (hpw_q != H_SYNC);
  assign err_frame = vfall && (v_meas != V_TOTAL);
  assign err_vpw   = vrise && (vpw_q != V_SYNC);
  assign err_stuck = !hfall && (h_cnt_q == 10'd1022);
  assign err_event = err_line | err_hpw | err_frame | err_vpw | err_stuck;

  always_comb begin
    hs_d      = h_sync;
    vs_d      = v_sync;
    hs_prev_d = hs_q;
    vs_prev_d = vs_q;

    h_cnt_d = h_cnt_q;
    if (hfall)                   h_cnt_d = '0;
    else if (h_cnt_q != 10'h3FF) h_cnt_d = h_cnt_q + 10'd1;

    v_cnt_d = v_cnt_q;
    if (vfall)                           v_cnt_d = '0;
    else if (hfall && v_cnt_q != 10'h3FF) v_cnt_d = v_cnt_q + 10'd1;

    hpw_d = hpw_q;
    if (hs_q)                  hpw_d = '0;
    else if (hpw_q != 8'hFF)   hpw_d = hpw_q + 8'd1;

    // v_sync width is measured in lines, i.e. h_sync edges seen while low.
    vpw_d = vpw_q;
    if (vs_q)                           vpw_d = '0;
    else if (hfall && vpw_q != 4'hF)    vpw_d = vpw_q + 4'd1;

    vfall_dly_d   = vfall;
    line_len_d    = (hfall && have_edge_q) ? h_meas : line_len_q;
    frame_lines_d = vfall ? v_meas : frame_lines_q;
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      SEARCH: begin
        good_d = '0;
        if (vfall) state_d = ACQUIRE;
      end
      ACQUIRE: begin
        if (err_event) begin
          state_d = SEARCH;
          good_d  = '0;
        end else if (vfall) begin
          good_d = good_q + 4'd1;
          if (good_q + 4'd1 == LOCK_FRAMES) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (err_event) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase

    have_edge_d = have_edge_q | hfall;
    if (state_d == SEARCH && state_q != SEARCH) have_edge_d = 1'b0;
  end

  always_comb begin
    col  = h_cnt_q - H_ACT_START;
    row  = v_cnt_q[8:0] - V_ACT_START[8:0];
    h_in = (h_cnt_q >= H_ACT_START) && (h_cnt_q <= H_ACT_END);
    v_in = (v_cnt_q >= V_ACT_START) && (v_cnt_q <= V_ACT_END);

    pixel_valid_d = (state_q == LOCKED) && h_in && v_in;
    addr_d        = pixel_valid_d ? {row, col} : '0;
    frame_start_d = vfall_dly_q && (state_q == LOCKED);
    locked_d      = (state_d == LOCKED);

    err_count_d = err_count_q;
    if (state_q == LOCKED && err_event && err_count_q != 8'hFF)
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      hs_q          <= 1'b1;
      hs_prev_q     <= 1'b1;
      vs_q          <= 1'b1;
      vs_prev_q     <= 1'b1;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hpw_q         <= '0;
      vpw_q         <= '0;
      have_edge_q   <= 1'b0;
      good_q        <= '0;
      vfall_dly_q   <= 1'b0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      addr_q        <= '0;
      pixel_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      err_count_q   <= '0;
    end else begin
      hs_q          <= hs_d;
      hs_prev_q     <= hs_prev_d;
      vs_q          <= vs_d;
      vs_prev_q     <= vs_prev_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hpw_q         <= hpw_d;
      vpw_q         <= vpw_d;
      have_edge_q   <= have_edge_d;
      good_q        <= good_d;
      vfall_dly_q   <= vfall_dly_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      addr_q        <= addr_d;
      pixel_valid_q <= pixel_valid_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      err_count_q   <= err_count_d;
    end
  end

  assign addr        = addr_q;
  assign pixel_valid = pixel_valid_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign err_count   = err_count_q;

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA timing generator: consumes raw h_sync/v_sync and recovers the pixel raster.
- Measures line and frame timing and checks them against the 640x480@60 timing.
- Locks onto the stream and regenerates the pixel address and active-video qualifier.
- Used for display-path self-test, and as the timing front end for a capture/overlay path clocked by the same vga_clk.

Parameters:
- H_TOTAL, 800, clocks per line.
- V_TOTAL, 525, lines per frame.
- H_SYNC, 96, h_sync low width in clocks.
- V_SYNC, 2, v_sync low width in lines.
- H_ACT_START, 143, first active column count.
- H_ACT_END, 782, last active column count.
- V_ACT_START, 35, first active line count.
- V_ACT_END, 514, last active line count.
- LOCK_FRAMES, 2, consecutive clean frames required to lock.

Ports:
- vga_clk  in  1  pixel clock, 25MHz; sole clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- h_sync  in  1  horizontal sync, low during pulse.
- v_sync  in  1  vertical sync, low during pulse.
- addr  out  19  recovered pixel address {row[8:0], col[9:0]}.
- pixel_valid  out  1  recovered active-video qualifier.
- frame_start  out  1  one-cycle pulse at each v_sync falling edge while locked.
- locked  out  1  timing matches parameters.
- line_len  out  10  last measured line length in clocks (saturating at 1023).
- frame_lines  out  10  last measured lines per frame (saturating at 1023).
- err_count  out  8  timing-violation counter, saturating at 255.

Behaviour:
- Reset (rst=0, async): all outputs 0; FSM=SEARCH; internal counters 0; sync input registers set to 1 (idle high).
- Input stage: h_sync and v_sync are registered once. Falling/rising edges are detected from the registered value vs its previous value.
- h_cnt (10b):
  - Cleared on a registered h_sync falling edge; otherwise increments.
  - Saturates at 1023.
  - At each falling edge, line_len <= h_cnt+1 (saturated). This is not done on the first edge after reset or after SEARCH entry.
- hpw (7b+): counts registered h_sync low cycles. On the rising edge, the width is compared to H_SYNC.
- v_cnt (10b): increments on each h_sync falling edge; cleared on a v_sync falling edge. If both edges occur in the same cycle, the v_sync clear wins and v_cnt=0.
- At a v_sync falling edge, frame_lines <= v_cnt+1 (saturated).
- v_sync low width is counted in h_sync edges and compared to V_SYNC at the v_sync rising edge.
- Violations (any of these is an error event, at most one per cycle):
  - line_len != H_TOTAL.
  - hsync width != H_SYNC.
  - frame_lines != V_TOTAL.
  - vsync width != V_SYNC.
  - h_cnt reaching 1023 (stuck/absent h_sync). Raised once, then h_cnt holds until the next edge.
- FSM:
  - SEARCH: wait for a v_sync falling edge, then go to ACQUIRE with good=0. Line and frame checks from before this edge are ignored.
  - ACQUIRE: at each v_sync falling edge, if the frame just ended had no error, good++. When good==LOCK_FRAMES, go to LOCKED. Any error returns to SEARCH; err_count is not incremented in ACQUIRE.
  - LOCKED: locked=1. Any error: err_count++ (saturating), locked deasserts the next cycle, go to SEARCH.
- Outputs:
  - pixel_valid=1 only while LOCKED with H_ACT_START<=h_cnt'<=H_ACT_END and V_ACT_START<=v_cnt'<=V_ACT_END, where h_cnt'/v_cnt' are the counts aligned to the generator's counters.
  - col = h_cnt' - H_ACT_START and row = v_cnt' - V_ACT_START, 10b wrap arithmetic. addr = {row[8:0], col} when pixel_valid, else 0.
  - Latency: in LOCKED, addr, pixel_valid and frame_start equal the generator's addr, v_active and counter-wrap-to-(0,0) pulse delayed by exactly 3 vga_clk cycles. All outputs are registered.
- Reset mid-operation: immediate return to reset state. Re-lock takes 1 partial frame plus LOCK_FRAMES full frames.

Test Plan:
- Generator-driven nominal stream from reset → locked rises within 3 v_sync falls. line_len=800, frame_lines=525, err_count=0.
- Locked, nominal → first pixel_valid cycle has addr=0; last cycle of a frame has addr={9'd479,10'd639}. 307200 valid cycles per frame; matches generator delayed 3 cycles.
- Locked, one line stretched to 801 clocks → locked drops, err_count=1, line_len=801. Relock after LOCK_FRAMES clean frames.
- Locked, h_sync held high → after 1023 clocks without an edge, err_count increments once, FSM=SEARCH, pixel_valid=0.
- v_sync low for 3 lines in ACQUIRE → back to SEARCH, err_count unchanged, locked stays 0.
- rst pulsed low mid-frame while locked → outputs 0 asynchronously. After release, locked returns after LOCK_FRAMES+1 v_sync falls.
